// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_access_pkg;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OP_READ, OP_WRITE} op_t;

    localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/wait_counter.sv
// Loadable down-counter that stops at zero; holds the remaining wait cycles of an access.
module wait_counter
    import mem_access_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_unit.sv
// Request/done sequencer holding address and data stable for a fixed number of memory wait cycles.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_WIDTH    = 13,
    parameter int DATA_WIDTH    = 8,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  ready,
    output logic                  done,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [CNT_WIDTH-1:0] RD_LOAD = CNT_WIDTH'(READ_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] WR_LOAD = CNT_WIDTH'(WRITE_LATENCY - 1);

    state_t state_q, state_d;
    op_t    op_q;
    logic   accept;
    logic   start;
    logic   conflict;
    logic   cnt_zero;

    assign accept   = (state_q != ACCESS);
    assign start    = accept && (req_read ^ req_write);
    assign conflict = accept && req_read && req_write;

    wait_counter #(.WIDTH(CNT_WIDTH)) u_wait_counter (
        .clk        (clk),
        .rst_n      (rst),
        .load       (start),
        .load_value (req_write ? WR_LOAD : RD_LOAD),
        .dec        (state_q == ACCESS),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            op_q      <= OP_READ;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            err       <= 1'b0;
        end else begin
            state_q <= state_d;
            err     <= conflict;
            if (start) begin
                op_q      <= req_write ? OP_WRITE : OP_READ;
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
            end
            if ((state_q == ACCESS) && (op_q == OP_READ) && cnt_zero) begin
                rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        done      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            IDLE: begin
                ready   = 1'b1;
                state_d = start ? ACCESS : IDLE;
            end
            ACCESS: begin
                mem_read  = (op_q == OP_READ);
                // A write commits only once, in the last wait cycle.
                mem_write = (op_q == OP_WRITE) && cnt_zero;
                if (cnt_zero) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                done    = 1'b1;
                state_d = start ? ACCESS : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequencer between the multi-cycle CPU data path and the byte-wide unified instruction/data memory. It accepts one read or write request at a time from the controller/data path over a request/done handshake, then holds the 13-bit address and write data stable for a parameterised number of wait cycles. It drives the memory read/write strobes and returns read bytes in a holding register. This lets the data path use memories slower than one cycle without changing controller state encoding.

Parameters:
ADDR_WIDTH, 13, address width (matches PC/TR width)
DATA_WIDTH, 8, data byte width
READ_LATENCY, 2, memory cycles per read, legal range 1..15
WRITE_LATENCY, 1, memory cycles per write, legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
req_read  in  1  read request, level, sampled when unit is ready
req_write  in  1  write request, level, sampled when unit is ready
req_addr  in  ADDR_WIDTH  request address (PC or TR mux output)
req_wdata  in  DATA_WIDTH  write data (register-file read_data2)
ready  out  1  1 when a request is accepted this cycle (IDLE or DONE state)
done  out  1  one-cycle pulse: access complete, rdata valid for reads
err  out  1  one-cycle pulse: req_read and req_write were both high at acceptance
rdata  out  DATA_WIDTH  last read byte, held until the next read completes
mem_addr  out  ADDR_WIDTH  memory address, registered
mem_wdata  out  DATA_WIDTH  memory write data, registered
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_rdata  in  DATA_WIDTH  memory read data, valid in last read cycle

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, wait counter 0. ready=1. done, err, mem_read and mem_write are 0. rdata, mem_addr and mem_wdata are 0.
- States: IDLE, ACCESS, DONE.
- Accepting a request (state IDLE or DONE, rising edge):
  - Exactly one of req_read/req_write high: latch req_addr into mem_addr, latch req_wdata into mem_wdata, latch the operation, load counter with LATENCY-1, go to ACCESS.
  - Both high: err=1 for the next cycle, no memory access, go to IDLE.
  - Neither high: go to IDLE.
- ACCESS:
  - mem_addr and mem_wdata stay stable. ready=0, and requests are ignored.
  - Read: mem_read=1 in every ACCESS cycle.
  - Write: mem_write=1 only in the final ACCESS cycle (counter==0). This gives one commit per write.
  - Counter decrements each cycle. When counter==0: a read captures mem_rdata into rdata, then the unit goes to DONE.
- DONE: done=1 for exactly one cycle, ready=1. A request present in DONE is accepted (back-to-back, no idle bubble).
- Latency: request sampled at edge N; ACCESS covers cycles N+1..N+LATENCY; done is high in cycle N+LATENCY+1. Throughput is one access per LATENCY+1 cycles.
- mem_read and mem_write are never high in the same cycle. Both are 0 in IDLE and DONE.
- The controller deasserts its request in the done cycle unless it wants a new access. A request level still high in DONE starts a new access.
- Reset mid-ACCESS: the access is aborted at once, strobes drop asynchronously, and no done pulse is issued.
- Counter width is 4 bits; LATENCY=1 gives exactly one ACCESS cycle.

Decomposition:
- Package mem_access_pkg:
  - state_t enum {IDLE, ACCESS, DONE}.
  - op_t enum {OP_READ, OP_WRITE}.
  - localparam CNT_WIDTH=4.
- Sub-module wait_counter (load, value, decrement, zero flag; async active-low reset). The FSM, request latches and rdata register stay in mem_access_unit.

Test Plan:
1. Reset: hold rst=0 with req_read=1 → ready=1, done=0, mem_read=0, rdata=8'h00. Release rst → read accepted on the first edge.
2. Read, READ_LATENCY=2, mem_rdata=8'hA5, req_addr=13'h0123 → mem_read=1 for 2 cycles with mem_addr=13'h0123, done high 3 cycles after acceptance, rdata=8'hA5 and held afterwards.
3. Write, WRITE_LATENCY=1, req_addr=13'h1FFF, req_wdata=8'h3C → mem_write=1 for exactly one cycle with mem_wdata=8'h3C and mem_addr=13'h1FFF, done in the next cycle, rdata unchanged.
4. Back-to-back: read held high through DONE, then a write to 13'h0010 → second access starts in the cycle after done, with no IDLE cycle and no strobe overlap.
5. req_read=1 and req_write=1 together → err pulses for one cycle, no strobes, no done, state IDLE.
6. rst=0 in the second cycle of a READ_LATENCY=3 read → mem_read=0 immediately, no done pulse after release, rdata=8'h00.
